// File: rtl/io_ctrl_pkg.sv
// Shared types and constants for the io_step_ctrl microstep sequencer.
package io_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T1W  = 4'd3,
    ST_T2   = 4'd4,
    ST_DEC  = 4'd5,
    ST_IN   = 4'd6,
    ST_OUT  = 4'd7,
    ST_END  = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  localparam logic [4:0] ALU_INC = 5'b11111;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;

  // One bit per DataPath strobe plus the status outputs the decoder owns.
  typedef struct packed {
    logic       pc_out;
    logic       mar_in;
    logic       z_in;
    logic       zlo_out;
    logic       pc_in;
    logic       mem_read;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       iport_out;
    logic       gra;
    logic       r_in;
    logic       r_out;
    logic       oport_in;
    logic       iport_ack;
    logic       oport_strobe;
    logic       busy;
    logic       illegal;
    logic [4:0] alu_code;
  } strobe_t;

endpackage

// File: rtl/io_step_decode.sv
// Combinational state -> strobe decoder. Everything is a function of the
// registered state, except the IN/OUT transfer strobes which are gated by the
// selected port's valid/ready in the same cycle.
module io_step_decode
  import io_ctrl_pkg::*;
(
  input  state_t  i_state,
  input  logic    i_fetch_done,
  input  logic    i_sel_valid,
  input  logic    i_sel_ready,
  output strobe_t o_strb
);

  // Decode the strobes for the current microstep.
  always_comb begin
    o_strb = '0;
    case (i_state)
      ST_T0: begin
        o_strb.pc_out   = 1'b1;
        o_strb.mar_in   = 1'b1;
        o_strb.z_in     = 1'b1;
        o_strb.alu_code = ALU_INC;
      end
      ST_T1, ST_T1W: begin
        o_strb.mem_read = 1'b1;
        if (i_fetch_done) begin
          o_strb.zlo_out = 1'b1;
          o_strb.pc_in   = 1'b1;
          o_strb.mdr_in  = 1'b1;
        end
      end
      ST_T2: begin
        o_strb.mdr_out = 1'b1;
        o_strb.ir_in   = 1'b1;
      end
      ST_IN: begin
        if (i_sel_valid) begin
          o_strb.iport_out = 1'b1;
          o_strb.gra       = 1'b1;
          o_strb.r_in      = 1'b1;
          o_strb.iport_ack = 1'b1;
        end
      end
      ST_OUT: begin
        if (i_sel_ready) begin
          o_strb.gra          = 1'b1;
          o_strb.r_out        = 1'b1;
          o_strb.oport_in     = 1'b1;
          o_strb.oport_strobe = 1'b1;
        end
      end
      ST_HALT: o_strb.illegal = 1'b1;
      default: ;
    endcase
    o_strb.busy = (i_state != ST_IDLE) && (i_state != ST_HALT);
  end

endmodule

// File: rtl/io_step_ctrl.sv
// Microstep sequencer for fetch / in / out. Holds the FSM, the memory wait
// counter, the latched port select and the completed-instruction counter.
//
// Port handshakes: a transfer happens in the single cycle where the FSM is in
// IN (resp. OUT) and iport_valid[port_sel] (resp. oport_ready[port_sel]) is
// high; iport_ack / oport_strobe mark exactly that cycle. While the selected
// valid/ready is low the FSM stalls with no strobes. Valid/ready outside
// IN/OUT are ignored.
module io_step_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int N_IPORT  = 1,
  parameter int N_OPORT  = 1,
  parameter int PSEL_W   = 3
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              run,
  input  logic [4:0]        ir_opcode,
  input  logic [PSEL_W-1:0] ir_port,
  input  logic [N_IPORT-1:0] iport_valid,
  input  logic [N_OPORT-1:0] oport_ready,
  output logic              PCOut,
  output logic              MARIn,
  output logic              ZIn,
  output logic              ZLoOut,
  output logic              PCIn,
  output logic              memread,
  output logic              MDRIn,
  output logic              MDROut,
  output logic              IRIn,
  output logic              IPortOut,
  output logic              Gra,
  output logic              RIn,
  output logic              ROut,
  output logic              OPortIn,
  output logic [4:0]        ALUCode,
  output logic [PSEL_W-1:0] port_sel,
  output logic              iport_ack,
  output logic              oport_strobe,
  output logic              busy,
  output logic              illegal,
  output logic [15:0]       instr_count,
  output logic [3:0]        dbg_state
);

  localparam logic [PSEL_W:0] LP_NI = (PSEL_W+1)'(N_IPORT);
  localparam logic [PSEL_W:0] LP_NO = (PSEL_W+1)'(N_OPORT);

  state_t            r_state;
  state_t            w_next;
  logic [PSEL_W-1:0] r_port_sel;
  logic [15:0]       r_instr_count;
  logic              w_fetch_done;
  logic              w_sel_valid;
  logic              w_sel_ready;
  logic              w_in_ok;
  logic              w_out_ok;
  strobe_t           w_strb;

  // Wait counter exists only when the memory needs extra read cycles.
  if (MEM_WAIT > 0) begin : g_wait
    logic [3:0] r_wait;

    // Load on T1, count down through T1W.
    always_ff @(posedge clock or posedge clear) begin
      if (clear) r_wait <= 4'd0;
      else if (r_state == ST_T1) r_wait <= 4'(MEM_WAIT - 1);
      else if (r_state == ST_T1W && r_wait != 4'd0) r_wait <= r_wait - 4'd1;
    end

    assign w_fetch_done = (r_state == ST_T1W) && (r_wait == 4'd0);
  end else begin : g_nowait
    assign w_fetch_done = (r_state == ST_T1);
  end

  // Select the valid/ready of the latched port.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_ready = 1'b0;
    for (int i = 0; i < N_IPORT; i++)
      if (r_port_sel == PSEL_W'(i)) w_sel_valid = iport_valid[i];
    for (int i = 0; i < N_OPORT; i++)
      if (r_port_sel == PSEL_W'(i)) w_sel_ready = oport_ready[i];
  end

  assign w_in_ok  = {1'b0, ir_port} < LP_NI;
  assign w_out_ok = {1'b0, ir_port} < LP_NO;

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_T0;
      ST_T0:   w_next = ST_T1;
      ST_T1:   w_next = w_fetch_done ? ST_T2 : ST_T1W;
      ST_T1W:  if (w_fetch_done) w_next = ST_T2;
      ST_T2:   w_next = ST_DEC;
      ST_DEC: begin
        if (ir_opcode == OP_IN && w_in_ok)        w_next = ST_IN;
        else if (ir_opcode == OP_OUT && w_out_ok) w_next = ST_OUT;
        else                                      w_next = ST_HALT;
      end
      ST_IN:   if (w_sel_valid) w_next = ST_END;
      ST_OUT:  if (w_sel_ready) w_next = ST_END;
      ST_END:  w_next = run ? ST_T0 : ST_IDLE;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  // Latch the port index when the instruction is decoded.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                  r_port_sel <= '0;
    else if (r_state == ST_DEC) r_port_sel <= ir_port;
  end

  // Count completed instructions; wraps naturally at 16 bits.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                  r_instr_count <= 16'd0;
    else if (r_state == ST_END) r_instr_count <= r_instr_count + 16'd1;
  end

  io_step_decode u_decode (
    .i_state      (r_state),
    .i_fetch_done (w_fetch_done),
    .i_sel_valid  (w_sel_valid),
    .i_sel_ready  (w_sel_ready),
    .o_strb       (w_strb)
  );

  assign PCOut        = w_strb.pc_out;
  assign MARIn        = w_strb.mar_in;
  assign ZIn          = w_strb.z_in;
  assign ZLoOut       = w_strb.zlo_out;
  assign PCIn         = w_strb.pc_in;
  assign memread      = w_strb.mem_read;
  assign MDRIn        = w_strb.mdr_in;
  assign MDROut       = w_strb.mdr_out;
  assign IRIn         = w_strb.ir_in;
  assign IPortOut     = w_strb.iport_out;
  assign Gra          = w_strb.gra;
  assign RIn          = w_strb.r_in;
  assign ROut         = w_strb.r_out;
  assign OPortIn      = w_strb.oport_in;
  assign ALUCode      = w_strb.alu_code;
  assign iport_ack    = w_strb.iport_ack;
  assign oport_strobe = w_strb.oport_strobe;
  assign busy         = w_strb.busy;
  assign illegal      = w_strb.illegal;
  assign port_sel     = r_port_sel;
  assign instr_count  = r_instr_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_io_step_ctrl.sv
// Bench for io_step_ctrl: two instances (MEM_WAIT=0 / 4 in, 4 out ports and
// MEM_WAIT=3 / 8 in, 2 out ports). Each instruction is expanded into a list
// of per-cycle input values and expected output vectors, then replayed.
module tb_io_step_ctrl;
  import io_ctrl_pkg::*;

  // Output vector bit positions (ALUCode in [22:18]).
  localparam logic [22:0] M_PCOUT  = 23'd1 << 0;
  localparam logic [22:0] M_MARIN  = 23'd1 << 1;
  localparam logic [22:0] M_ZIN    = 23'd1 << 2;
  localparam logic [22:0] M_ZLO    = 23'd1 << 3;
  localparam logic [22:0] M_PCIN   = 23'd1 << 4;
  localparam logic [22:0] M_MEMRD  = 23'd1 << 5;
  localparam logic [22:0] M_MDRIN  = 23'd1 << 6;
  localparam logic [22:0] M_MDROUT = 23'd1 << 7;
  localparam logic [22:0] M_IRIN   = 23'd1 << 8;
  localparam logic [22:0] M_IPORT  = 23'd1 << 9;
  localparam logic [22:0] M_GRA    = 23'd1 << 10;
  localparam logic [22:0] M_RIN    = 23'd1 << 11;
  localparam logic [22:0] M_ROUT   = 23'd1 << 12;
  localparam logic [22:0] M_OPORT  = 23'd1 << 13;
  localparam logic [22:0] M_ACK    = 23'd1 << 14;
  localparam logic [22:0] M_STB    = 23'd1 << 15;
  localparam logic [22:0] M_BUSY   = 23'd1 << 16;
  localparam logic [22:0] M_ILL    = 23'd1 << 17;
  localparam logic [22:0] M_ALUINC = 23'h1F << 18;

  localparam logic [22:0] V_IDLE = 23'd0;
  localparam logic [22:0] V_T0   = M_PCOUT | M_MARIN | M_ZIN | M_ALUINC | M_BUSY;
  localparam logic [22:0] V_WAIT = M_MEMRD | M_BUSY;
  localparam logic [22:0] V_T1   = M_ZLO | M_PCIN | M_MEMRD | M_MDRIN | M_BUSY;
  localparam logic [22:0] V_T2   = M_MDROUT | M_IRIN | M_BUSY;
  localparam logic [22:0] V_BUSY = M_BUSY;
  localparam logic [22:0] V_IN   = M_IPORT | M_GRA | M_RIN | M_ACK | M_BUSY;
  localparam logic [22:0] V_OUT  = M_GRA | M_ROUT | M_OPORT | M_STB | M_BUSY;
  localparam logic [22:0] V_HALT = M_ILL;

  typedef struct packed {
    logic       run;
    logic [4:0] op;
    logic [2:0] port;
    logic [7:0] iv;
    logic [7:0] ordy;
  } stim_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  logic       run0, run1;
  logic [4:0] op0, op1;
  logic [2:0] port0, port1;
  logic [3:0] iv0, or0;
  logic [7:0] iv1;
  logic [1:0] or1;

  wire [22:0] obs0, obs1;
  wire [15:0] cnt0, cnt1;
  wire [2:0]  psel0, psel1;
  wire [3:0]  dbg0, dbg1;

  io_step_ctrl #(.MEM_WAIT(0), .N_IPORT(4), .N_OPORT(4), .PSEL_W(3)) dut0 (
    .clock(clock), .clear(clear), .run(run0), .ir_opcode(op0), .ir_port(port0),
    .iport_valid(iv0), .oport_ready(or0),
    .PCOut(obs0[0]), .MARIn(obs0[1]), .ZIn(obs0[2]), .ZLoOut(obs0[3]), .PCIn(obs0[4]),
    .memread(obs0[5]), .MDRIn(obs0[6]), .MDROut(obs0[7]), .IRIn(obs0[8]),
    .IPortOut(obs0[9]), .Gra(obs0[10]), .RIn(obs0[11]), .ROut(obs0[12]), .OPortIn(obs0[13]),
    .iport_ack(obs0[14]), .oport_strobe(obs0[15]), .busy(obs0[16]), .illegal(obs0[17]),
    .ALUCode(obs0[22:18]), .port_sel(psel0), .instr_count(cnt0), .dbg_state(dbg0)
  );

  io_step_ctrl #(.MEM_WAIT(3), .N_IPORT(8), .N_OPORT(2), .PSEL_W(3)) dut1 (
    .clock(clock), .clear(clear), .run(run1), .ir_opcode(op1), .ir_port(port1),
    .iport_valid(iv1), .oport_ready(or1),
    .PCOut(obs1[0]), .MARIn(obs1[1]), .ZIn(obs1[2]), .ZLoOut(obs1[3]), .PCIn(obs1[4]),
    .memread(obs1[5]), .MDRIn(obs1[6]), .MDROut(obs1[7]), .IRIn(obs1[8]),
    .IPortOut(obs1[9]), .Gra(obs1[10]), .RIn(obs1[11]), .ROut(obs1[12]), .OPortIn(obs1[13]),
    .iport_ack(obs1[14]), .oport_strobe(obs1[15]), .busy(obs1[16]), .illegal(obs1[17]),
    .ALUCode(obs1[22:18]), .port_sel(psel1), .instr_count(cnt1), .dbg_state(dbg1)
  );

  // ---------------- reference model state ----------------
  stim_t       stim_q[$];
  logic [41:0] exp_q[$];   // {vector[22:0], instr_count[15:0], port_sel[2:0]}
  logic [15:0] m_cnt[2];
  logic [2:0]  m_psel[2];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic int mw_of(input int d); return (d == 0) ? 0 : 3; endfunction
  function automatic int ni_of(input int d); return (d == 0) ? 4 : 8; endfunction
  function automatic int no_of(input int d); return (d == 0) ? 4 : 2; endfunction

  function automatic logic [22:0] obs_of(input int d); return (d == 0) ? obs0 : obs1; endfunction
  function automatic logic [15:0] cnt_of(input int d); return (d == 0) ? cnt0 : cnt1; endfunction
  function automatic logic [2:0]  psel_of(input int d); return (d == 0) ? psel0 : psel1; endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  // ---------------- stimulus builders ----------------
  function automatic stim_t rnd_stim(input logic run, input logic [4:0] op, input logic [2:0] port);
    stim_t s;
    s.run  = run;
    s.op   = op;
    s.port = port;
    s.iv   = 8'($urandom);
    s.ordy = 8'($urandom);
    return s;
  endfunction

  task automatic push(input int d, input stim_t s, input logic [22:0] v);
    stim_q.push_back(s);
    exp_q.push_back({v, m_cnt[d], m_psel[d]});
  endtask

  // n idle cycles with run low, optionally one more with run high to start.
  task automatic add_idle(input int d, input int n, input logic start);
    for (int i = 0; i < n; i++) push(d, rnd_stim(1'b0, 5'($urandom), 3'($urandom)), V_IDLE);
    if (start) push(d, rnd_stim(1'b1, 5'($urandom), 3'($urandom)), V_IDLE);
  endtask

  // One instruction from T0: fetch, decode, transfer after `stall` wait
  // cycles, END with run = run_after. Illegal ones end in 4 HALT cycles.
  task automatic add_instr(input int d, input logic [4:0] op, input logic [2:0] port,
                           input int stall, input logic run_after);
    stim_t s;
    push(d, rnd_stim(1'($urandom), op, port), V_T0);
    for (int i = 0; i < mw_of(d); i++) push(d, rnd_stim(1'($urandom), op, port), V_WAIT);
    push(d, rnd_stim(1'($urandom), op, port), V_T1);
    push(d, rnd_stim(1'($urandom), op, port), V_T2);
    push(d, rnd_stim(1'($urandom), op, port), V_BUSY);
    m_psel[d] = port;
    if (op == OP_IN && int'(port) < ni_of(d)) begin
      for (int i = 0; i < stall; i++) begin
        s = rnd_stim(1'($urandom), op, port); s.iv[port] = 1'b0; push(d, s, V_BUSY);
      end
      s = rnd_stim(1'($urandom), op, port); s.iv[port] = 1'b1; push(d, s, V_IN);
      push(d, rnd_stim(run_after, op, port), V_BUSY);
      m_cnt[d] = m_cnt[d] + 16'd1;
    end else if (op == OP_OUT && int'(port) < no_of(d)) begin
      for (int i = 0; i < stall; i++) begin
        s = rnd_stim(1'($urandom), op, port); s.ordy[port] = 1'b0; push(d, s, V_BUSY);
      end
      s = rnd_stim(1'($urandom), op, port); s.ordy[port] = 1'b1; push(d, s, V_OUT);
      push(d, rnd_stim(run_after, op, port), V_BUSY);
      m_cnt[d] = m_cnt[d] + 16'd1;
    end else begin
      for (int i = 0; i < 4; i++) push(d, rnd_stim(1'($urandom), op, port), V_HALT);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input int d, input stim_t s);
    if (d == 0) begin
      run0 = s.run; op0 = s.op; port0 = s.port; iv0 = s.iv[3:0]; or0 = s.ordy[3:0];
    end else begin
      run1 = s.run; op1 = s.op; port1 = s.port; iv1 = s.iv; or1 = s.ordy[1:0];
    end
  endtask

  // Replay queued cycles (all of them when limit < 0).
  task automatic run_sched(input int d, input int limit);
    int    n;
    stim_t s;
    logic [41:0] e;
    n = stim_q.size();
    if (limit >= 0 && limit < n) n = limit;
    for (int c = 0; c < n; c++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(posedge clock);
      #1 apply(d, s);
      @(negedge clock);
      chk($sformatf("d%0d c%0d vec", d, c), 32'(obs_of(d)), 32'(e[41:19]));
      chk($sformatf("d%0d c%0d cnt", d, c), 32'(cnt_of(d)), 32'(e[18:3]));
      chk($sformatf("d%0d c%0d psel", d, c), 32'(psel_of(d)), 32'(e[2:0]));
    end
  endtask

  task automatic gen_seq(input int d, input int n);
    logic [4:0] op;
    logic [2:0] port;
    logic       chain;
    add_idle(d, $urandom_range(0, 2), 1'b1);
    for (int i = 0; i < n; i++) begin
      op    = $urandom_range(0, 1) ? OP_IN : OP_OUT;
      port  = 3'($urandom_range(0, ((op == OP_IN) ? ni_of(d) : no_of(d)) - 1));
      chain = (i < n - 1) && ($urandom_range(0, 1) == 1);
      add_instr(d, op, port, $urandom_range(0, 3), chain);
      if (!chain && i < n - 1) add_idle(d, $urandom_range(0, 2), 1'b1);
    end
    add_idle(d, 1, 1'b0);
    run_sched(d, -1);
  endtask

  // Assert clear just after a negedge: everything must drop at once.
  task automatic do_clear(input string tag);
    run0 = 1'b0;
    run1 = 1'b0;
    clear = 1'b1;
    #1;
    chk({tag, " vec0"}, 32'(obs0), 32'(V_IDLE));
    chk({tag, " vec1"}, 32'(obs1), 32'(V_IDLE));
    chk({tag, " cnt0"}, 32'(cnt0), 32'd0);
    chk({tag, " cnt1"}, 32'(cnt1), 32'd0);
    chk({tag, " psel0"}, 32'(psel0), 32'd0);
    chk({tag, " psel1"}, 32'(psel1), 32'd0);
    chk({tag, " st0"}, 32'(dbg0), 32'(ST_IDLE));
    chk({tag, " st1"}, 32'(dbg1), 32'(ST_IDLE));
    @(negedge clock);
    clear = 1'b0;
    stim_q.delete();
    exp_q.delete();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]  = 16'd0;
      m_psel[d] = 3'd0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    apply(0, '0);
    apply(1, '0);
    clear = 1'b1;
    repeat (3) @(negedge clock);
    do_clear("reset");

    // in, port 0, no stall, no wait states
    add_idle(0, 0, 1'b1);
    add_instr(0, OP_IN, 3'd0, 0, 1'b0);
    add_idle(0, 1, 1'b0);
    run_sched(0, -1);

    // three wait states on fetch; in on port 7
    add_idle(1, 0, 1'b1);
    add_instr(1, OP_IN, 3'd7, 2, 1'b0);
    add_idle(1, 1, 1'b0);
    run_sched(1, -1);

    // out to port 2, ready low for 6 cycles
    add_idle(0, 0, 1'b1);
    add_instr(0, OP_OUT, 3'd2, 6, 1'b0);
    add_idle(0, 1, 1'b0);
    run_sched(0, -1);

    // back-to-back instructions with run held high
    add_idle(1, 0, 1'b1);
    add_instr(1, OP_OUT, 3'd1, 1, 1'b1);
    add_instr(1, OP_IN, 3'd3, 0, 1'b0);
    add_idle(1, 1, 1'b0);
    run_sched(1, -1);

    gen_seq(0, 12);
    gen_seq(1, 12);

    // clear during an IN stall (idle + T0,T1,T2,DEC + 2 stall cycles)
    add_idle(0, 0, 1'b1);
    add_instr(0, OP_IN, 3'd1, 10, 1'b0);
    run_sched(0, 7);
    do_clear("clr_stall");
    add_idle(0, 1, 1'b1);
    add_instr(0, OP_IN, 3'd2, 1, 1'b0);
    add_idle(0, 1, 1'b0);
    run_sched(0, -1);

    // illegal opcode
    add_idle(0, 0, 1'b1);
    add_instr(0, 5'b00000, 3'd0, 0, 1'b0);
    run_sched(0, -1);
    do_clear("clr_op0");

    // in to a port that does not exist
    add_idle(0, 0, 1'b1);
    add_instr(0, OP_IN, 3'd5, 0, 1'b0);
    run_sched(0, -1);
    do_clear("clr_port5");

    // out to a missing port on the wait-state instance
    add_idle(1, 0, 1'b1);
    add_instr(1, OP_OUT, 3'd3, 0, 1'b0);
    run_sched(1, -1);
    do_clear("clr_oport3");

    // instruction counter wrap
    @(negedge clock);
    force dut0.r_instr_count = 16'hFFFF;
    @(negedge clock);
    release dut0.r_instr_count;
    m_cnt[0] = 16'hFFFF;
    @(negedge clock);
    chk("preload", 32'(cnt0), 32'(m_cnt[0]));
    add_idle(0, 0, 1'b1);
    add_instr(0, OP_OUT, 3'd1, 1, 1'b0);
    add_idle(0, 1, 1'b0);
    run_sched(0, -1);
    chk("wrap", 32'(cnt0), 32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/io_step_ctrl.md
# io_step_ctrl

Parametrised microstep sequencer for the DataPath's fetch, `in` and `out` instructions. It replaces hand-sequenced T0–T3 control with an FSM that drives the DataPath control strobes directly. It adds memory wait states, multiple input and output ports with valid/ready handshakes, stall-until-ready behaviour, and illegal-opcode trapping. It sits beside DataPath and reads the opcode and port fields from the IR.

## Interface
Parameters:
- MEM_WAIT, 0: extra cycles memread is held before MDRIn (0–15).
- N_IPORT, 1: number of input ports (1–8).
- N_OPORT, 1: number of output ports (1–8).
- PSEL_W, 3: width of the port-select field.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- clear  in  1  asynchronous, active-high reset.
- run  in  1  start/continue fetching; sampled in IDLE and at the end of each instruction.
- ir_opcode  in  5  IR[31:27].
- ir_port  in  PSEL_W  port index field from IR.
- iport_valid  in  N_IPORT  per-port input data valid.
- oport_ready  in  N_OPORT  per-port output sink ready.
- PCOut, MARIn, ZIn, ZLoOut, PCIn, memread, MDRIn, MDROut, IRIn, IPortOut, Gra, RIn, ROut, OPortIn  out  1 each  DataPath strobes.
- ALUCode  out  5  11111 (increment) in T0, otherwise 0.
- port_sel  out  PSEL_W  registered copy of ir_port; selects the port mux.
- iport_ack  out  1  one-cycle pulse when input data is consumed.
- oport_strobe  out  1  one-cycle pulse when output data is written.
- busy  out  1  high in any state except IDLE and HALT.
- illegal  out  1  sticky; set on entry to HALT.
- instr_count  out  16  number of completed instructions; wraps at 0xFFFF→0.

## Operation
States and the strobes each one asserts (all other strobes 0):
- IDLE: no strobes. Goes to T0 if run=1.
- T0: PCOut, MARIn, ZIn, ALUCode=11111. Goes to T1.
- T1: ZLoOut, PCIn, memread, MDRIn. Goes to T2.
  - If MEM_WAIT>0, T1 instead asserts memread only and loads a wait counter with MEM_WAIT−1. It then moves to T1W.
- T1W: memread. Counter decrements each cycle. At 0 the state asserts ZLoOut, PCIn, memread, MDRIn and goes to T2.
- T2: MDROut, IRIn. Goes to DEC.
- DEC: no strobes. Latches port_sel ← ir_port.
  - Opcode 10110 (`in`): go to IN.
  - Opcode 10111 (`out`): go to OUT.
  - Any other opcode, or port index ≥ N_IPORT/N_OPORT: go to HALT.
- IN: stalls with no strobes while iport_valid[port_sel]=0. When valid=1, asserts IPortOut, Gra, RIn, iport_ack for exactly one cycle, then goes to END.
- OUT: stalls with no strobes while oport_ready[port_sel]=0. When ready=1, asserts Gra, ROut, OPortIn, oport_strobe for one cycle, then goes to END.
- END: instr_count increments. Goes to T0 if run=1, otherwise IDLE.
- HALT: no strobes, illegal=1. Stays here until clear.

## Timing
- All outputs are Moore outputs decoded from the registered state, except iport_ack/oport_strobe and the IN/OUT data strobes. Those are gated combinationally by valid/ready in the same cycle.
- Reset value of every output is 0; state resets to IDLE, counters to 0, and port_sel to 0.
- `in` latency with valid already high, from T0 to END: 5+MEM_WAIT cycles. Each stall cycle adds 1.
- Asserting clear mid-instruction immediately drops all strobes, including during a stall. Partial register writes are never completed.
- run falling mid-instruction does not abort; it is only honoured in IDLE and END.
- iport_valid toggling while the FSM is not in IN is ignored.
- MEM_WAIT=0 builds no counter.

## Structure
- Package io_ctrl_pkg holds:
  - the state enum;
  - constants ALU_INC=5'b11111, OP_IN=5'b10110, OP_OUT=5'b10111.
- Sub-module io_step_decode: combinational state→strobe decoder.
- The top level keeps the FSM, the wait counter, port_sel and instr_count.

## Test plan
- Reset, then run=1, opcode=10110, port 0 with valid=1, MEM_WAIT=0 → strobe sequence T0..END over 5 cycles; iport_ack pulses once; instr_count=1.
- MEM_WAIT=3 fetch → memread high for 4 consecutive cycles; MDRIn only on the last of them.
- `out` to port 2 (N_OPORT=4) with oport_ready low for 6 cycles → OUT holds 6 cycles with no strobes; then OPortIn and oport_strobe high for one cycle with port_sel=2.
- Opcode 00000, or `in` to port 5 with N_IPORT=4 → HALT; illegal=1 and stays 1; busy=0; no RIn ever asserted.
- clear pulsed during an IN stall → all outputs 0 within the same cycle; state IDLE; instr_count=0.
- Force instr_count to 0xFFFF, then one instruction → instr_count wraps to 0.
